enigma_sequencer: RTL and testbench

ENIGMA_SEQUENCER -- requirements
Module: enigma_sequencer

---
 rtl/enigma_pkg.sv | 22 ++
 rtl/enigma_sequencer.sv | 166 ++++++++++++++++
 tb/tb_enigma_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma letter sequencer: letter encoding and FSM state type.
package enigma_pkg;

    localparam int LETTER_W = 5;
    localparam logic [LETTER_W-1:0] SPACE_CODE  = 5'd26;
    localparam logic [LETTER_W-1:0] LAST_LETTER = 5'd25;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STEP   = 3'd2,
        SETTLE = 3'd3,
        ENCODE = 3'd4,
        OUTPUT = 3'd5,
        SPACE  = 3'd6
    } seq_state_t;

    function automatic logic is_letter(input logic [LETTER_W-1:0] code);
        return (code <= LAST_LETTER);
    endfunction

endpackage

// File: rtl/enigma_sequencer.sv
// Per-letter sequencer: accept key, step rotors, settle, run scrambler, emit ciphertext.
// Optional five-letter grouping with a space code is enabled by ENIGMA_SEQ_GROUP5_EN.
module enigma_sequencer
    import enigma_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cfg_load,
    input  logic                key_valid,
    input  logic [LETTER_W-1:0] key_in,
    output logic                key_ready,
    output logic                rotor_load,
    output logic                rotor_rotate,
    output logic                enc_req,
    output logic [LETTER_W-1:0] enc_letter,
    input  logic                enc_done,
    input  logic [LETTER_W-1:0] enc_result,
    output logic                out_valid,
    output logic [LETTER_W-1:0] out_letter,
    input  logic                out_ready,
    output logic                bad_key,
    output logic [CNT_W-1:0]    char_count
);

    localparam logic [2:0]       SETTLE_LAST = 3'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t          state_r, state_s;
    logic                loaded_r;
    logic [LETTER_W-1:0] key_r, result_r, result_s;
    logic [2:0]          settle_cnt_r;
    logic [CNT_W-1:0]    count_r;
    logic                key_take_s, bad_s, enc_take_s, out_take_s;
    logic                key_ready_r, rotor_load_r, rotor_rotate_r, enc_req_r;
    logic                out_valid_r, bad_key_r;
    logic [LETTER_W-1:0] enc_letter_r, out_letter_r, out_letter_s;
`ifdef ENIGMA_SEQ_GROUP5_EN
    logic [2:0]          group_cnt_r;
`endif

    // Handshake events; cfg_load overrides every one of them.
    always_comb begin
        key_take_s = 1'b0;
        bad_s      = 1'b0;
        enc_take_s = 1'b0;
        out_take_s = 1'b0;
        if (!cfg_load) begin
            key_take_s = (state_r == IDLE) && key_valid && key_ready_r && is_letter(key_in);
            bad_s      = (state_r == IDLE) && key_valid && key_ready_r && !is_letter(key_in);
            enc_take_s = (state_r == ENCODE) && enc_done;
            out_take_s = (state_r == OUTPUT) && out_ready;
        end else begin
            key_take_s = 1'b0;
        end
        if (enc_take_s) begin
            result_s = enc_result;
        end else begin
            result_s = result_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        if (cfg_load) begin
            state_s = LOAD;
        end else begin
            case (state_r)
                IDLE:    state_s = key_take_s ? STEP : IDLE;
                LOAD:    state_s = IDLE;
                STEP:    state_s = SETTLE;
                SETTLE:  state_s = (settle_cnt_r == SETTLE_LAST) ? ENCODE : SETTLE;
                ENCODE:  state_s = enc_take_s ? OUTPUT : ENCODE;
`ifdef ENIGMA_SEQ_GROUP5_EN
                OUTPUT:  state_s = out_take_s ? ((group_cnt_r == 3'd4) ? SPACE : IDLE) : OUTPUT;
                SPACE:   state_s = out_ready ? IDLE : SPACE;
`else
                OUTPUT:  state_s = out_take_s ? IDLE : OUTPUT;
`endif
                default: state_s = IDLE;
            endcase
        end
    end

    // Letter presented on the ciphertext port for the upcoming state.
    always_comb begin
        out_letter_s = 5'd0;
        case (state_s)
            OUTPUT:  out_letter_s = result_s;
`ifdef ENIGMA_SEQ_GROUP5_EN
            SPACE:   out_letter_s = SPACE_CODE;
`endif
            default: out_letter_s = 5'd0;
        endcase
    end

    // State, datapath and registered outputs (decoded from the next state so they align with it).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            loaded_r       <= 1'b0;
            key_r          <= 5'd0;
            result_r       <= 5'd0;
            settle_cnt_r   <= 3'd0;
            count_r        <= {CNT_W{1'b0}};
            key_ready_r    <= 1'b0;
            rotor_load_r   <= 1'b0;
            rotor_rotate_r <= 1'b0;
            enc_req_r      <= 1'b0;
            enc_letter_r   <= 5'd0;
            out_valid_r    <= 1'b0;
            out_letter_r   <= 5'd0;
            bad_key_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            loaded_r       <= loaded_r || (state_r == LOAD);
            key_r          <= key_take_s ? key_in : key_r;
            result_r       <= result_s;
            settle_cnt_r   <= (state_r == SETTLE) ? (settle_cnt_r + 3'd1) : 3'd0;
            if (state_r == LOAD) begin
                count_r <= {CNT_W{1'b0}};
            end else if (out_take_s) begin
                count_r <= count_r + CNT_ONE;
            end else begin
                count_r <= count_r;
            end
            key_ready_r    <= (state_s == IDLE) && (loaded_r || (state_r == LOAD));
            rotor_load_r   <= (state_s == LOAD);
            rotor_rotate_r <= (state_s == STEP);
            enc_req_r      <= (state_s == ENCODE);
            enc_letter_r   <= (state_s == ENCODE) ? key_r : 5'd0;
            out_valid_r    <= (state_s == OUTPUT) || (state_s == SPACE);
            out_letter_r   <= out_letter_s;
            bad_key_r      <= bad_s;
        end
    end

`ifdef ENIGMA_SEQ_GROUP5_EN
    // Letters emitted in the current five-letter group.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            group_cnt_r <= 3'd0;
        end else if (state_r == LOAD) begin
            group_cnt_r <= 3'd0;
        end else if (out_take_s) begin
            group_cnt_r <= (group_cnt_r == 3'd4) ? 3'd0 : (group_cnt_r + 3'd1);
        end else begin
            group_cnt_r <= group_cnt_r;
        end
    end
`endif

    assign key_ready    = key_ready_r;
    assign rotor_load   = rotor_load_r;
    assign rotor_rotate = rotor_rotate_r;
    assign enc_req      = enc_req_r;
    assign enc_letter   = enc_letter_r;
    assign out_valid    = out_valid_r;
    assign out_letter   = out_letter_r;
    assign bad_key      = bad_key_r;
    assign char_count   = count_r;

endmodule

// File: tb/tb_enigma_sequencer.sv
// Directed, table-driven bench for enigma_sequencer (honours ENIGMA_SEQ_GROUP5_EN when defined).
module tb_enigma_sequencer;
    import enigma_pkg::*;

    localparam int SETTLE = 1;
    localparam int CW     = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_load = 1'b0;
    logic          key_valid = 1'b0;
    logic [4:0]    key_in = 5'd0;
    logic          key_ready, rotor_load, rotor_rotate, enc_req;
    logic [4:0]    enc_letter;
    logic          enc_done = 1'b0;
    logic [4:0]    enc_result = 5'd0;
    logic          out_valid;
    logic [4:0]    out_letter;
    logic          out_ready = 1'b0;
    logic          bad_key;
    logic [CW-1:0] char_count;

    int tests = 0;
    int fails = 0;
    int exp_count = 0;

    typedef struct {
        logic [4:0] key;
        int         enc_wait;
        int         rdy_wait;
        logic [4:0] result;
    } vec_t;
    vec_t vecs[10];

    enigma_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .cfg_load(cfg_load),
        .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
        .rotor_load(rotor_load), .rotor_rotate(rotor_rotate),
        .enc_req(enc_req), .enc_letter(enc_letter), .enc_done(enc_done), .enc_result(enc_result),
        .out_valid(out_valid), .out_letter(out_letter), .out_ready(out_ready),
        .bad_key(bad_key), .char_count(char_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("load_pulse", 32'(rotor_load), 32'd1);
        check("load_no_ready", 32'(key_ready), 32'd0);
        check("load_no_valid", 32'(out_valid), 32'd0);
        check("load_no_req", 32'(enc_req), 32'd0);
        tick();
        check("load_pulse_end", 32'(rotor_load), 32'd0);
        check("load_count_clr", 32'(char_count), 32'd0);
        check("load_ready", 32'(key_ready), 32'd1);
        exp_count = 0;
    endtask

    task automatic do_letter(input logic [4:0] k, input int enc_wait, input int rdy_wait,
                             input logic [4:0] res);
        int held;
        check("ready_before_key", 32'(key_ready), 32'd1);
        key_valid = 1'b1;
        key_in    = k;
        tick();
        key_valid = 1'b0;
        key_in    = 5'd0;
        check("step_rotate", 32'(rotor_rotate), 32'd1);
        check("step_no_req", 32'(enc_req), 32'd0);
        check("step_no_ready", 32'(key_ready), 32'd0);
        for (int i = 0; i < SETTLE; i++) begin
            tick();
            check("settle_no_req", 32'(enc_req), 32'd0);
            check("settle_no_rotate", 32'(rotor_rotate), 32'd0);
        end
        tick();
        held = 0;
        for (int i = 0; i < enc_wait; i++) begin
            held += int'(enc_req);
            check("enc_letter_wait", 32'(enc_letter), 32'(k));
            tick();
        end
        enc_done   = 1'b1;
        enc_result = res;
        held += int'(enc_req);
        check("enc_letter", 32'(enc_letter), 32'(k));
        check("no_valid_in_encode", 32'(out_valid), 32'd0);
        tick();
        enc_done   = 1'b0;
        enc_result = 5'd0;
        check("enc_req_hold", 32'(held), 32'(enc_wait + 1));
        check("enc_req_drop", 32'(enc_req), 32'd0);
        check("enc_letter_zero", 32'(enc_letter), 32'd0);
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_letter", 32'(out_letter), 32'(res));
        for (int i = 0; i < rdy_wait; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_letter", 32'(out_letter), 32'(res));
            check("stall_count", 32'(char_count), 32'(exp_count));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_count++;
        check("char_count", 32'(char_count), 32'(exp_count));
`ifdef ENIGMA_SEQ_GROUP5_EN
        if (exp_count % 5 == 0) begin
            check("space_valid", 32'(out_valid), 32'd1);
            check("space_letter", 32'(out_letter), 32'd26);
            check("space_no_ready", 32'(key_ready), 32'd0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("space_count", 32'(char_count), 32'(exp_count));
        end
`endif
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_letter", 32'(out_letter), 32'd0);
        check("idle_ready", 32'(key_ready), 32'd1);
    endtask

    initial begin
        int rot_seen;
        int rdy_seen;
        vecs[0] = '{key: 5'd0,  enc_wait: 0, rdy_wait: 0, result: 5'd1};
        vecs[1] = '{key: 5'd5,  enc_wait: 4, rdy_wait: 3, result: 5'd17};
        vecs[2] = '{key: 5'd25, enc_wait: 0, rdy_wait: 1, result: 5'd3};
        vecs[3] = '{key: 5'd12, enc_wait: 2, rdy_wait: 0, result: 5'd25};
        vecs[4] = '{key: 5'd1,  enc_wait: 1, rdy_wait: 2, result: 5'd0};
        vecs[5] = '{key: 5'd19, enc_wait: 0, rdy_wait: 0, result: 5'd8};
        vecs[6] = '{key: 5'd7,  enc_wait: 3, rdy_wait: 0, result: 5'd22};
        vecs[7] = '{key: 5'd24, enc_wait: 0, rdy_wait: 4, result: 5'd14};
        vecs[8] = '{key: 5'd16, enc_wait: 1, rdy_wait: 1, result: 5'd6};
        vecs[9] = '{key: 5'd9,  enc_wait: 0, rdy_wait: 0, result: 5'd30};

        tick();
        tick();
        check("rst_ready", 32'(key_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_req", 32'(enc_req), 32'd0);
        check("rst_count", 32'(char_count), 32'd0);

        // No key may be taken until a load has completed.
        reset_n   = 1'b1;
        key_valid = 1'b1;
        key_in    = 5'd0;
        rot_seen  = 0;
        rdy_seen  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            rot_seen += int'(rotor_rotate);
            rdy_seen += int'(key_ready);
        end
        key_valid = 1'b0;
        check("noload_ready", 32'(rdy_seen), 32'd0);
        check("noload_rotate", 32'(rot_seen), 32'd0);

        do_load();
        do_letter(5'd0, 0, 0, 5'd1);

        // Out-of-range key codes.
        for (int b = 26; b < 32; b += 5) begin
            key_valid = 1'b1;
            key_in    = 5'(b);
            tick();
            key_valid = 1'b0;
            key_in    = 5'd0;
            check("bad_key_pulse", 32'(bad_key), 32'd1);
            check("bad_no_rotate", 32'(rotor_rotate), 32'd0);
            check("bad_ready", 32'(key_ready), 32'd1);
            tick();
            check("bad_key_end", 32'(bad_key), 32'd0);
            check("bad_no_rotate2", 32'(rotor_rotate), 32'd0);
        end
        check("bad_count", 32'(char_count), 32'd1);

        do_load();
        for (int v = 0; v < 10; v++) begin
            do_letter(vecs[v].key, vecs[v].enc_wait, vecs[v].rdy_wait, vecs[v].result);
        end
        check("ten_count", 32'(char_count), 32'd10);

        enc_done   = 1'b1;
        enc_result = 5'd9;
        tick();
        enc_done   = 1'b0;
        enc_result = 5'd0;
        check("stray_done_valid", 32'(out_valid), 32'd0);
        check("stray_done_ready", 32'(key_ready), 32'd1);

        // Reload while the scrambler request is outstanding.
        key_valid = 1'b1;
        key_in    = 5'd3;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < SETTLE + 1; i++) tick();
        check("abort_in_encode", 32'(enc_req), 32'd1);
        cfg_load = 1'b1;
        enc_done = 1'b1;
        tick();
        cfg_load = 1'b0;
        enc_done = 1'b0;
        check("abort_load", 32'(rotor_load), 32'd1);
        check("abort_req", 32'(enc_req), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        tick();
        check("abort_count", 32'(char_count), 32'd0);
        check("abort_valid2", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(key_ready), 32'd1);
        exp_count = 0;
        do_letter(5'd7, 1, 0, 5'd12);

        // Asynchronous reset between clock edges.
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_ready", 32'(key_ready), 32'd0);
        check("async_count", 32'(char_count), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_ready", 32'(key_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
